sprite_anim: RTL and testbench
==============================

SPRITE_ANIM -- requirements
Module: sprite_anim

Interface
REQ-001 Parameters SHALL be as follows, one per entry:
- FRAME_W, default 64, sprite width in source pixels; power of two.
- FRAME_H, default 64, sprite height in source pixels; power of two.
- SCALE_LOG2, default 3, scale factor is 2^SCALE_LOG2.
- NUM_FRAMES, default 12, animation frames held in ROM.
- FRAME_PERIOD, default 2_835_000, px_clk cycles per animation step.
- FRAMES_FILE, default "nyancat-frames.hex", index ROM image.
- COLORS_FILE, default "nyancat-colors.hex", 16x6b palette image.
REQ-002 Ports SHALL be as follows, one per entry:
- px_clk, in, 1, pixel clock; one clock, all logic on its rising edge.
- reset, in, 1, synchronous, active-high.
- x_px, in, 10, current pixel column.
- y_px, in, 10, current pixel row.
- activevideo, in, 1, active display region.
- frame_start, in, 1, one-cycle pulse at the start of each video frame.
- pos_x, in, 10, new sprite left edge.
- pos_y, in, 10, new sprite top edge.
- pos_we, in, 1, write pending position.
- mode, in, 2, playback mode (REQ-008).
- pause, in, 1, freezes the sequencer.
- transp_en, in, 1, enables transparency.
- transp_idx, in, 4, index treated as transparent.
- bg_color, in, 6, colour shown for transparent pixels and outside the sprite.
- rrggbb, out, 6, colour output.
- frame_index, out, $clog2(NUM_FRAMES), current frame.
- done, out, 1, one-shot playback finished.

Function
REQ-003 Window: SW = FRAME_W<<SCALE_LOG2, SH = FRAME_H<<SCALE_LOG2; a pixel is in the window when pos_x_act <= x_px < pos_x_act+SW and pos_y_act <= y_px < pos_y_act+SH, computed at 11-bit width so there is no wrap-around; the window may be partially off-screen.
REQ-004 Source coordinates SHALL be src_x=(x_px-pos_x_act)>>SCALE_LOG2 and src_y likewise; ROM address = {frame_index, src_y, src_x} by concatenation, with no multiply.
REQ-005 Pipeline SHALL be 2 cycles from inputs to output: stage 1 reads the index ROM; stage 2 reads the palette; in-window flag, activevideo and the transparency decision are delayed by 2.
REQ-006 Output: rrggbb = 0 if delayed activevideo is 0; else bg_color if outside the window, or if transp_en and index==transp_idx; else the palette colour.
REQ-007 Position SHALL be double-buffered: pos_we loads the shadow register; frame_start copies shadow to active; pos_we and frame_start in the same cycle SHALL make the new value active immediately.
REQ-008 Sequencer: cycle counter 0..FRAME_PERIOD-1 steps the frame on wrap; pause holds both counter and frame.
- mode 00 (loop): 0..N-1, then 0.
- mode 01 (ping-pong): 0..N-1..0 without repeating the endpoints; direction register.
- mode 10 (one-shot): stops at N-1 and asserts done.
- mode 11: behaves as loop.
REQ-009 A change of mode SHALL restart the sequence: frame 0, counter 0, direction up, done 0.
REQ-010 With NUM_FRAMES=1, frame_index SHALL stay 0 in every mode; done SHALL assert after the first period in one-shot.

Reset
REQ-011 Reset SHALL clear the counter, frame_index, direction, done, both pipeline stages and all delayed flags; rrggbb reads 0 on the next cycle.
REQ-012 Reset SHALL load the shadow and active positions with ((640-SW)/2, 0).
REQ-013 Reset mid-frame SHALL take effect in the same clock, with no partial pixels emitted afterwards.

Configuration
REQ-014 With SPRITE_ANIM_MIRROR_EN defined, a port mirror_x (in, 1) SHALL be present and, when high, src_x = FRAME_W-1-src_x.
REQ-015 Without SPRITE_ANIM_MIRROR_EN, the mirror_x port and its logic SHALL be absent.

Structure
REQ-016 Package sprite_anim_pkg SHALL hold the mode encodings (MODE_LOOP, MODE_PINGPONG, MODE_ONESHOT) and the colour width constant.
REQ-017 The frame sequencer SHALL be sub-module sprite_anim_seq (ports px_clk, reset, mode, pause, frame_index, done); the ROMs and pipeline stay in the top level.

Verification
REQ-018 Directed scenarios:
- Defaults, FRAME_PERIOD=4, mode 00: frame_index sequence 0,1,...,11,0, each frame lasting 4 cycles.
- NUM_FRAMES=4, mode 01: frame_index sequence 0,1,2,3,2,1,0,1.
- Mode 10: stops at 11, done=1 and held; a mode change to 00 gives frame_index=0 and done=0.
- pos_we with (100,50) mid-frame: no effect until frame_start; afterwards pixel (100,50) maps to ROM address {frame,0,0}, (99,50) outputs bg_color, and output is valid exactly 2 cycles later.
- transp_en=1, transp_idx=0, ROM index 0 at a pixel: output = bg_color; activevideo=0: output = 0; reset asserted: rrggbb=0 next cycle.
- With SPRITE_ANIM_MIRROR_EN and mirror_x=1: pixel (pos_x_act, pos_y_act) reads src_x=FRAME_W-1.

Source files
------------

// File: rtl/sprite_anim_pkg.sv
// sprite_anim_pkg: shared playback-mode encodings, colour width and helper functions
// for the sprite animator. It also holds the generator functions for the built-in
// sprite image.
package sprite_anim_pkg;

    localparam int COLOR_W = 6;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'b00,
        MODE_PINGPONG = 2'b01,
        MODE_ONESHOT  = 2'b10
    } mode_e;

    // Width of a frame number. A single-frame sprite still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Built-in index image: a frame-dependent XOR checker of the source coordinates.
    function automatic logic [3:0] idx_image(input logic [3:0] f, input logic [3:0] y,
                                             input logic [3:0] x);
        return f ^ y ^ x;
    endfunction

    // Built-in 16-entry palette: the index in the upper bits, never black.
    function automatic logic [COLOR_W-1:0] palette_image(input logic [3:0] i);
        return {i, 2'b11};
    endfunction

endpackage

// File: rtl/sprite_anim_seq.sv
// sprite_anim_seq: animation frame sequencer. A cycle counter steps the frame on wrap,
// in loop, ping-pong or one-shot order. A change of mode restarts playback.
module sprite_anim_seq
    import sprite_anim_pkg::*;
#(
    parameter int NUM_FRAMES   = 12,
    parameter int FRAME_PERIOD = 2_835_000
) (
    input  logic                         px_clk,
    input  logic                         reset,
    input  logic [1:0]                   mode,
    input  logic                         pause,
    output logic [idx_w(NUM_FRAMES)-1:0] frame_index,
    output logic                         done
);

    localparam int                FW       = idx_w(NUM_FRAMES);
    localparam int                CW       = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(FRAME_PERIOD - 1);
    localparam logic [FW-1:0]     LAST     = FW'(NUM_FRAMES - 1);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] frame_q, frame_d;
    dir_e          dir_q, dir_d;
    logic          done_q, done_d;
    logic [1:0]    mode_q;

    assign frame_index = frame_q;
    assign done        = done_q;

    // Sequencer state register. The previous mode is kept so that a mode change can be detected.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            cnt_q   <= '0;
            frame_q <= '0;
            dir_q   <= DIR_UP;
            done_q  <= 1'b0;
            mode_q  <= mode;
        end else begin
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            mode_q  <= mode;
        end
    end

    // Next-state logic: restart on a mode change; otherwise step the frame on counter wrap unless paused.
    always_comb begin
        cnt_d   = cnt_q;
        frame_d = frame_q;
        dir_d   = dir_q;
        done_d  = done_q;
        if (mode != mode_q) begin
            cnt_d   = '0;
            frame_d = '0;
            dir_d   = DIR_UP;
            done_d  = 1'b0;
        end else if (!pause) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                case (mode)
                    MODE_PINGPONG: begin
                        // The endpoints are shown once per sweep; a single frame never moves.
                        if (NUM_FRAMES > 1) begin
                            if (dir_q == DIR_UP) begin
                                if (frame_q == LAST) begin
                                    frame_d = frame_q - FW'(1);
                                    dir_d   = DIR_DOWN;
                                end else begin
                                    frame_d = frame_q + FW'(1);
                                end
                            end else begin
                                if (frame_q == '0) begin
                                    frame_d = frame_q + FW'(1);
                                    dir_d   = DIR_UP;
                                end else begin
                                    frame_d = frame_q - FW'(1);
                                end
                            end
                        end
                    end
                    MODE_ONESHOT: begin
                        if (frame_q == LAST) done_d = 1'b1;
                        else                 frame_d = frame_q + FW'(1);
                    end
                    default: begin
                        frame_d = (frame_q == LAST) ? '0 : frame_q + FW'(1);
                    end
                endcase
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_anim.sv
// sprite_anim: an animated, integer-scaled sprite overlaid on the video raster. It has a
// double-buffered position, a two-stage index-ROM / palette pipeline and transparency.
// Optional feature: defining SPRITE_ANIM_MIRROR_EN adds the mirror_x port, which gives a
// horizontal flip.
// FRAMES_FILE and COLORS_FILE name the production image files. This build takes its
// ROM contents from the package generator functions, so it elaborates without external files.
module sprite_anim
    import sprite_anim_pkg::*;
#(
    parameter int FRAME_W      = 64,
    parameter int FRAME_H      = 64,
    parameter int SCALE_LOG2   = 3,
    parameter int NUM_FRAMES   = 12,
    parameter int FRAME_PERIOD = 2_835_000,
    parameter     FRAMES_FILE  = "nyancat-frames.hex",
    parameter     COLORS_FILE  = "nyancat-colors.hex"
) (
    input  logic                         px_clk,
    input  logic                         reset,
    input  logic [9:0]                   x_px,
    input  logic [9:0]                   y_px,
    input  logic                         activevideo,
    input  logic                         frame_start,
    input  logic [9:0]                   pos_x,
    input  logic [9:0]                   pos_y,
    input  logic                         pos_we,
    input  logic [1:0]                   mode,
    input  logic                         pause,
    input  logic                         transp_en,
    input  logic [3:0]                   transp_idx,
    input  logic [COLOR_W-1:0]           bg_color,
`ifdef SPRITE_ANIM_MIRROR_EN
    input  logic                         mirror_x,
`endif
    output logic [COLOR_W-1:0]           rrggbb,
    output logic [idx_w(NUM_FRAMES)-1:0] frame_index,
    output logic                         done
);

    localparam int            XB        = $clog2(FRAME_W);
    localparam int            YB        = $clog2(FRAME_H);
    localparam int            FW        = idx_w(NUM_FRAMES);
    localparam int            SW        = FRAME_W << SCALE_LOG2;
    localparam int            SH        = FRAME_H << SCALE_LOG2;
    localparam int            STAGES    = 2;
    localparam logic [9:0]    POS_X_RST = 10'((640 - SW) / 2);

    logic [9:0]          shadow_x, shadow_y, pos_x_act, pos_y_act;
    logic [10:0]         win_x_end, win_y_end;
    logic                in_win;
    logic [XB-1:0]       src_x_raw, src_x;
    logic [YB-1:0]       src_y;
    logic [FW+YB+XB-1:0] rom_addr;
    logic [3:0]          idx_s1;
    logic [COLOR_W-1:0]  col_s2;
    logic                transp_s2;
    logic [STAGES:1]     vld_pipe, win_pipe;

    sprite_anim_seq #(
        .NUM_FRAMES  (NUM_FRAMES),
        .FRAME_PERIOD(FRAME_PERIOD)
    ) u_seq (
        .px_clk     (px_clk),
        .reset      (reset),
        .mode       (mode),
        .pause      (pause),
        .frame_index(frame_index),
        .done       (done)
    );

    // Position double buffer. The shadow register takes writes and frame_start publishes it.
    // A write arriving together with frame_start goes straight to the active position.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            shadow_x  <= POS_X_RST;
            shadow_y  <= '0;
            pos_x_act <= POS_X_RST;
            pos_y_act <= '0;
        end else begin
            if (pos_we) begin
                shadow_x <= pos_x;
                shadow_y <= pos_y;
            end
            if (frame_start) begin
                pos_x_act <= pos_we ? pos_x : shadow_x;
                pos_y_act <= pos_we ? pos_y : shadow_y;
            end
        end
    end

    // The window compare uses 11-bit width, so a sprite hanging off the right or bottom edge does not wrap.
    assign win_x_end = {1'b0, pos_x_act} + 11'(SW);
    assign win_y_end = {1'b0, pos_y_act} + 11'(SH);
    assign in_win    = ({1'b0, x_px} >= {1'b0, pos_x_act}) && ({1'b0, x_px} < win_x_end) &&
                       ({1'b0, y_px} >= {1'b0, pos_y_act}) && ({1'b0, y_px} < win_y_end);

    // Source texel is the window offset divided by the scale. Outside the window the value is unused.
    assign src_x_raw = XB'((x_px - pos_x_act) >> SCALE_LOG2);
    assign src_y     = YB'((y_px - pos_y_act) >> SCALE_LOG2);

`ifdef SPRITE_ANIM_MIRROR_EN
    // FRAME_W is a power of two, so FRAME_W-1-src_x is a bitwise inversion.
    assign src_x = mirror_x ? ~src_x_raw : src_x_raw;
`else
    assign src_x = src_x_raw;
`endif

    assign rom_addr = {frame_index, src_y, src_x};

    // Pipeline stages. Stage 1 reads the index ROM and stage 2 reads the palette and
    // decides transparency. The window and activevideo flags travel alongside.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            idx_s1    <= '0;
            col_s2    <= '0;
            transp_s2 <= 1'b0;
            vld_pipe  <= '0;
            win_pipe  <= '0;
        end else begin
            idx_s1    <= idx_image(4'(rom_addr[XB+YB +: FW]), 4'(rom_addr[XB +: YB]),
                                   4'(rom_addr[0 +: XB]));
            col_s2    <= palette_image(idx_s1);
            transp_s2 <= transp_en && (idx_s1 == transp_idx);
            vld_pipe  <= {vld_pipe[STAGES-1:1], activevideo};
            win_pipe  <= {win_pipe[STAGES-1:1], in_win};
        end
    end

    // Output mux: black during blanking; background outside the sprite or on a transparent index.
    always_comb begin
        rrggbb = '0;
        if (vld_pipe[STAGES]) begin
            if (!win_pipe[STAGES] || transp_s2) rrggbb = bg_color;
            else                                rrggbb = col_s2;
        end
    end

endmodule

// File: tb/tb_sprite_anim.sv
// tb_sprite_anim: directed bench for sprite_anim. It covers loop, ping-pong and one-shot
// sequencing, the pixel pipeline, transparency, the double-buffered position and reset.
module tb_sprite_anim;
    import sprite_anim_pkg::*;

    logic       px_clk = 1'b0;
    logic       reset;
    logic [9:0] x_px, y_px, pos_x, pos_y;
    logic       activevideo, frame_start, pos_we, pause, transp_en;
    logic [1:0] mode, mode4, mode1;
    logic [3:0] transp_idx;
    logic [5:0] bg_color;
    logic       mirror_x;
    logic [5:0] rgb, rgb4, rgb1;
    logic [3:0] fi;
    logic [1:0] fi4;
    logic [0:0] fi1;
    logic       done, done4, done1;

    int checks = 0;
    int fails  = 0;
    int pp [6] = '{0, 1, 2, 3, 2, 1};

    always #5 px_clk = ~px_clk;

    sprite_anim #(.FRAME_PERIOD(4)) u_dut (
        .px_clk(px_clk), .reset(reset), .x_px(x_px), .y_px(y_px),
        .activevideo(activevideo), .frame_start(frame_start),
        .pos_x(pos_x), .pos_y(pos_y), .pos_we(pos_we), .mode(mode), .pause(pause),
        .transp_en(transp_en), .transp_idx(transp_idx), .bg_color(bg_color),
`ifdef SPRITE_ANIM_MIRROR_EN
        .mirror_x(mirror_x),
`endif
        .rrggbb(rgb), .frame_index(fi), .done(done)
    );

    sprite_anim #(.NUM_FRAMES(4), .FRAME_PERIOD(4)) u_dut4 (
        .px_clk(px_clk), .reset(reset), .x_px(x_px), .y_px(y_px),
        .activevideo(activevideo), .frame_start(frame_start),
        .pos_x(pos_x), .pos_y(pos_y), .pos_we(pos_we), .mode(mode4), .pause(pause),
        .transp_en(transp_en), .transp_idx(transp_idx), .bg_color(bg_color),
`ifdef SPRITE_ANIM_MIRROR_EN
        .mirror_x(mirror_x),
`endif
        .rrggbb(rgb4), .frame_index(fi4), .done(done4)
    );

    sprite_anim #(.NUM_FRAMES(1), .FRAME_PERIOD(4)) u_dut1 (
        .px_clk(px_clk), .reset(reset), .x_px(x_px), .y_px(y_px),
        .activevideo(activevideo), .frame_start(frame_start),
        .pos_x(pos_x), .pos_y(pos_y), .pos_we(pos_we), .mode(mode1), .pause(pause),
        .transp_en(transp_en), .transp_idx(transp_idx), .bg_color(bg_color),
`ifdef SPRITE_ANIM_MIRROR_EN
        .mirror_x(mirror_x),
`endif
        .rrggbb(rgb1), .frame_index(fi1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a pixel, let it cross both pipeline stages, then compare the main DUT output.
    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic av,
                       input string tag, input logic [5:0] exp);
        x_px        = x;
        y_px        = y;
        activevideo = av;
        @(negedge px_clk);
        @(negedge px_clk);
        chk(tag, 32'(rgb), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; x_px = 10'd64; y_px = 10'd0; activevideo = 1'b1;
        frame_start = 1'b0; pos_x = '0; pos_y = '0; pos_we = 1'b0;
        mode = 2'b00; mode4 = 2'b01; mode1 = 2'b10; pause = 1'b0;
        transp_en = 1'b0; transp_idx = 4'd0; bg_color = 6'h2A; mirror_x = 1'b0;
        @(negedge px_clk);
        @(negedge px_clk);
        chk("reset_rgb0", 32'(rgb), 32'd0);
        chk("reset_frame0", 32'(fi), 32'd0);
        chk("reset_done0", 32'(done), 32'd0);
        reset = 1'b0;

        // Loop, ping-pong and single-frame one-shot running side by side
        for (int p = 0; p <= 52; p++) begin
            chk("loop_frame", 32'(fi), 32'((p / 4) % 12));
            if (p < 32) chk("pingpong_frame", 32'(fi4), 32'(pp[(p / 4) % 6]));
            if (p == 3) chk("single_done_early", 32'(done1), 32'd0);
            if (p == 4) chk("single_done", 32'(done1), 32'd1);
            if (p == 20) chk("single_frame", 32'(fi1), 32'd0);
            @(negedge px_clk);
        end

        // One-shot: restart on mode change, stop at 11, done held
        mode = 2'b10;
        @(negedge px_clk);
        for (int p = 0; p <= 56; p++) begin
            chk("oneshot_frame", 32'(fi), 32'((p / 4 > 11) ? 11 : p / 4));
            chk("oneshot_done", 32'(done), 32'(p >= 48));
            @(negedge px_clk);
        end
        mode  = 2'b00;
        pause = 1'b1;
        @(negedge px_clk);
        chk("modechg_frame", 32'(fi), 32'd0);
        chk("modechg_done", 32'(done), 32'd0);
        repeat (9) @(negedge px_clk);
        chk("pause_hold", 32'(fi), 32'd0);

        // Pixel path at frame 0, sprite at (64,0), 512x512 window
        pix(10'd64,  10'd0,   1'b1, "px_origin",     6'd3);
        pix(10'd104, 10'd24,  1'b1, "px_inner",      6'd27);
        pix(10'd63,  10'd0,   1'b1, "px_left_out",   6'h2A);
        pix(10'd575, 10'd0,   1'b1, "px_right_edge", 6'd63);
        pix(10'd576, 10'd0,   1'b1, "px_right_out",  6'h2A);
        pix(10'd72,  10'd511, 1'b1, "px_bot_edge",   6'd59);
        pix(10'd72,  10'd512, 1'b1, "px_bot_out",    6'h2A);
        transp_en = 1'b1;
        pix(10'd64,  10'd0,   1'b1, "transp_hit",    6'h2A);
        pix(10'd104, 10'd24,  1'b1, "transp_miss",   6'd27);
        transp_en = 1'b0;
        pix(10'd104, 10'd24,  1'b0, "blanking",      6'd0);

        // Exact two-cycle latency
        x_px = 10'd104; y_px = 10'd24; activevideo = 1'b1;
        @(negedge px_clk);
        chk("latency_1", 32'(rgb), 32'd0);
        @(negedge px_clk);
        chk("latency_2", 32'(rgb), 32'd27);

        // Shadow write mid-frame has no effect until frame_start
        pos_x = 10'd100; pos_y = 10'd50; pos_we = 1'b1;
        @(negedge px_clk);
        pos_we = 1'b0;
        pix(10'd100, 10'd50, 1'b1, "shadow_only",      6'd11);
        pix(10'd99,  10'd50, 1'b1, "shadow_only_left", 6'd11);
        frame_start = 1'b1;
        @(negedge px_clk);
        frame_start = 1'b0;
        pix(10'd100, 10'd50, 1'b1, "pos_new_origin",   6'd3);
        pix(10'd99,  10'd50, 1'b1, "pos_new_left",     6'h2A);

        // Write and frame_start together: active immediately
        pos_x = 10'd200; pos_y = 10'd100; pos_we = 1'b1; frame_start = 1'b1;
        @(negedge px_clk);
        pos_we = 1'b0; frame_start = 1'b0;
        pix(10'd200, 10'd100, 1'b1, "pos_same_cycle", 6'd3);
        pix(10'd100, 10'd50,  1'b1, "pos_same_old",   6'h2A);

        // Reset with a sprite pixel in flight
        pix(10'd200, 10'd100, 1'b1, "pre_reset", 6'd3);
        reset = 1'b1;
        @(negedge px_clk);
        chk("reset_mid_rgb", 32'(rgb), 32'd0);
        chk("reset_mid_frame", 32'(fi), 32'd0);
        reset = 1'b0;
        pix(10'd64,  10'd0,   1'b1, "reset_pos",     6'd3);
        pix(10'd200, 10'd100, 1'b1, "reset_pos_far", 6'd55);

`ifdef SPRITE_ANIM_MIRROR_EN
        mirror_x = 1'b1;
        pix(10'd64, 10'd0, 1'b1, "mirror_origin", 6'd63);
        mirror_x = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
